// File: rtl/dma_multi_channel_ctrl.sv
// N-channel round-robin DMA controller writing peripheral words into data memory.
// Owns the memory port; passes the CPU through only while idle, stalling it during a grant.
module dma_multi_channel_ctrl #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_mem_rd,
  input  logic                     cpu_mem_wr,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_stall,
  input  logic [N_CH-1:0]          ch_valid,
  output logic [N_CH-1:0]          ch_ready,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic [CH_W-1:0]          active_ch
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HANDOVER = 2'd1;
  localparam logic [1:0] XFER     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [3:0]      BURST_LEN = 4'(MAX_BURST);

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic              grant_vld_q, grant_vld_d;

  logic              grant_found;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   idx_c;
  int                idx;
  logic              act_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Round-robin search starting at rr_ptr; wrap by compare so N_CH need not be a power of 2.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    idx_c       = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_c = idx[CH_W-1:0];
      if (!grant_found && ch_valid[idx_c]) begin
        grant_found = 1'b1;
        grant_ch    = idx_c;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (CH_W'(i) == active_ch_q) begin
        sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
        sel_data = ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign act_vld = ch_valid[active_ch_q];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    active_ch_d = active_ch_q;
    beat_cnt_d  = beat_cnt_q;
    grant_vld_d = grant_vld_q;
    case (state_q)
      IDLE: begin
        if (|ch_valid) state_d = HANDOVER;
      end
      HANDOVER: begin
        grant_vld_d = grant_found;
        beat_cnt_d  = '0;
        if (grant_found) begin
          active_ch_d = grant_ch;
          state_d     = XFER;
        end else begin
          state_d = RELEASE;
        end
      end
      XFER: begin
        if (!act_vld) begin
          state_d = RELEASE;
        end else begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (beat_cnt_q + 4'd1 == BURST_LEN) state_d = RELEASE;
        end
      end
      default: begin
        // A withdrawn request leaves the rotation where it was.
        if (grant_vld_q) rr_ptr_d = (active_ch_q == LAST_CH) ? '0 : active_ch_q + 1'b1;
        grant_vld_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      active_ch_q <= '0;
      beat_cnt_q  <= '0;
      grant_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      active_ch_q <= active_ch_d;
      beat_cnt_q  <= beat_cnt_d;
      grant_vld_q <= grant_vld_d;
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ch_ready  = '0;
    if (state_q == IDLE) begin
      mem_rd    = cpu_mem_rd;
      mem_wr    = cpu_mem_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (state_q == XFER) begin
      ch_ready[active_ch_q] = 1'b1;
      mem_wr    = act_vld;
      mem_addr  = sel_addr;
      mem_wdata = sel_data;
    end
  end

  assign cpu_stall = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign active_ch = active_ch_q;
  assign cpu_rdata = mem_rdata;

endmodule
